// File: rtl/ap_ctrl_chain_driver_if.sv
// Block-level ap_ctrl_chain control handshake between a driver and an HLS kernel.
// The master drives start/continue; the kernel answers with ready/done.
interface ap_ctrl_chain_driver_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (
    output ap_start,
    output ap_continue,
    input  ap_ready,
    input  ap_done
  );

  modport slave (
    input  ap_start,
    input  ap_continue,
    output ap_ready,
    output ap_done
  );
endinterface

// File: rtl/ap_ctrl_chain_driver.sv
// Issues a configured number of ap_ctrl_chain transactions, grants ap_continue under
// downstream backpressure and measures start-to-done latency through a timestamp FIFO.
module ap_ctrl_chain_driver #(
  parameter int CNT_W           = 32,
  parameter int LAT_W           = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_start_i,
  input  logic [CNT_W-1:0]       cfg_num_txn_i,
  input  logic                   cont_hold_i,
  ap_ctrl_chain_driver_if.master ap_if,
  output logic                   busy_o,
  output logic                   finish_o,
  output logic [CNT_W-1:0]       started_cnt_o,
  output logic [CNT_W-1:0]       done_cnt_o,
  output logic [LAT_W-1:0]       cycle_cnt_o,
  output logic                   lat_valid_o,
  output logic [LAT_W-1:0]       lat_value_o,
  output logic [LAT_W-1:0]       lat_max_o,
  output logic [LAT_W-1:0]       lat_min_o,
  output logic                   proto_err_o
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [LAT_W-1:0] ONE_L    = LAT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_e;
  state_e state_q, state_d;

  logic [CNT_W-1:0] num_q, started_q, done_q;
  logic [LAT_W-1:0] cycle_q, lat_value_q, lat_max_q, lat_min_q;
  logic             lat_valid_q, proto_err_q;
  logic [LAT_W-1:0] ts_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;

  logic             busy, run_req, ap_start, ap_continue, accept, done_seen, retire, spurious;
  logic [LAT_W-1:0] lat_now;

  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign ap_start    = (state_q == S_RUN) && (started_q < num_q) &&
                       ((started_q - done_q) < MAX_OUT);
  assign ap_continue = busy && !cont_hold_i;
  assign accept      = ap_start && ap_if.ap_ready;
  assign done_seen   = ap_if.ap_done && ap_continue;
  // FIFO occupancy is judged at cycle start, so a same-cycle push cannot cover a done
  assign retire      = done_seen && (occ_q != '0);
  assign spurious    = done_seen && (occ_q == '0);
  assign lat_now     = cycle_q - ts_mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run_req = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (cfg_start_i) begin
          run_req = 1'b1;
          state_d = (cfg_num_txn_i == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && ((started_q + ONE_C) == num_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((done_q + CNT_W'(retire)) == num_q) state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_q       <= '0;
      started_q   <= '0;
      done_q      <= '0;
      cycle_q     <= '0;
      lat_valid_q <= 1'b0;
      lat_value_q <= '0;
      lat_max_q   <= '0;
      lat_min_q   <= '1;
      proto_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      lat_valid_q <= 1'b0;
      if (run_req) begin
        num_q       <= cfg_num_txn_i;
        started_q   <= '0;
        done_q      <= '0;
        cycle_q     <= '0;
        lat_value_q <= '0;
        lat_max_q   <= '0;
        lat_min_q   <= '1;
        proto_err_q <= 1'b0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        occ_q       <= '0;
      end else begin
        if (busy) cycle_q <= cycle_q + ONE_L;
        if (accept) begin
          started_q <= started_q + ONE_C;
          wr_ptr_q  <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (retire) begin
          done_q      <= done_q + ONE_C;
          rd_ptr_q    <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
          lat_valid_q <= 1'b1;
          lat_value_q <= lat_now;
          if (lat_now > lat_max_q) lat_max_q <= lat_now;
          if (lat_now < lat_min_q) lat_min_q <= lat_now;
        end
        if (spurious) proto_err_q <= 1'b1;
        occ_q <= occ_q + OCC_W'(accept) - OCC_W'(retire);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) ts_mem_q[wr_ptr_q] <= cycle_q;
  end

  assign ap_if.ap_start    = ap_start;
  assign ap_if.ap_continue = ap_continue;
  assign busy_o            = busy;
  assign finish_o          = (state_q == S_FINISH);
  assign started_cnt_o     = started_q;
  assign done_cnt_o        = done_q;
  assign cycle_cnt_o       = cycle_q;
  assign lat_valid_o       = lat_valid_q;
  assign lat_value_o       = lat_value_q;
  assign lat_max_o         = lat_max_q;
  assign lat_min_o         = lat_min_q;
  assign proto_err_o       = proto_err_q;
endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Bench for ap_ctrl_chain_driver: a queue-based kernel and latency reference model
// checked cycle by cycle, plus directed scenarios and randomized runs.
module tb_ap_ctrl_chain_driver;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_num;
  logic        cont_hold;
  logic        busy, finish, lat_valid, proto_err;
  logic [31:0] started_cnt, done_cnt, cycle_cnt, lat_value, lat_max, lat_min;

  ap_ctrl_chain_driver_if ap_if ();

  ap_ctrl_chain_driver #(.CNT_W(32), .LAT_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_start_i(cfg_start), .cfg_num_txn_i(cfg_num),
    .cont_hold_i(cont_hold), .ap_if(ap_if), .busy_o(busy), .finish_o(finish),
    .started_cnt_o(started_cnt), .done_cnt_o(done_cnt), .cycle_cnt_o(cycle_cnt),
    .lat_valid_o(lat_valid), .lat_value_o(lat_value), .lat_max_o(lat_max),
    .lat_min_o(lat_min), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: run status, counts and a queue of accept timestamps
  bit          m_busy, m_fin, m_err, m_lvalid;
  logic [31:0] m_num, m_started, m_done, m_cyc, m_lv, m_max, m_min;
  logic [31:0] ts_q[$];
  // kernel: queue of absolute due cycles for outstanding dones
  longint      g = 0;
  longint      k_due[$];
  int          kdelay = 1;
  bit          kdelay_rand, ready_rand, hold_rand, spur;
  int          n_pulses, max_out_seen;
  bit          start_low_at_limit, saw_start;

  task automatic model_reset();
    m_busy = 0; m_fin = 0; m_err = 0; m_lvalid = 0;
    m_num = 0; m_started = 0; m_done = 0; m_cyc = 0; m_lv = 0; m_max = 0; m_min = '1;
    ts_q.delete();
    k_due.delete();
  endtask

  task automatic step();
    bit          p_cfg, p_ready, p_done, p_hold, e_start, e_cont;
    logic [31:0] p_num, lat, d_out;
    #1;
    p_cfg = cfg_start; p_num = cfg_num; p_ready = ap_if.ap_ready;
    p_done = ap_if.ap_done; p_hold = cont_hold;
    e_start = m_busy && (m_started < m_num) && ((m_started - m_done) < 4);
    e_cont  = m_busy && !p_hold;
    n_checks++;
    if (ap_if.ap_start !== e_start) begin
      n_err++; $display("FAIL ap_start got=%0b exp=%0b t=%0t", ap_if.ap_start, e_start, $time);
    end
    n_checks++;
    if (ap_if.ap_continue !== e_cont) begin
      n_err++; $display("FAIL ap_continue got=%0b exp=%0b t=%0t", ap_if.ap_continue, e_cont, $time);
    end
    if (ap_if.ap_start === 1'b1) saw_start = 1;
    if (ap_if.ap_start === 1'b0 && busy === 1'b1 && started_cnt < m_num &&
        (started_cnt - done_cnt) == 4) start_low_at_limit = 1;
    @(posedge clk);
    #1;
    m_lvalid = 0;
    if (p_cfg && !m_busy) begin
      m_num = p_num; m_started = 0; m_done = 0; m_cyc = 0; m_lv = 0; m_max = 0; m_min = '1;
      m_err = 0; ts_q.delete(); k_due.delete();
      m_busy = (p_num != 0); m_fin = (p_num == 0);
    end else if (m_busy) begin
      if (p_done && e_cont) begin
        if (ts_q.size() > 0) begin
          lat = m_cyc - ts_q.pop_front();
          m_done++; m_lvalid = 1; m_lv = lat;
          if (lat > m_max) m_max = lat;
          if (lat < m_min) m_min = lat;
          if (k_due.size() > 0) void'(k_due.pop_front());
        end else begin
          m_err = 1;
        end
      end
      if (e_start && p_ready) begin
        ts_q.push_back(m_cyc);
        m_started++;
        k_due.push_back(g + (kdelay_rand ? longint'($urandom_range(1, 8)) : longint'(kdelay)));
      end
      m_cyc++;
      if (m_done == m_num) begin m_busy = 0; m_fin = 1; end
    end
    g++;
    n_checks++;
    if ({busy, finish, proto_err} !== {m_busy, m_fin, m_err}) begin
      n_err++; $display("FAIL status busy/finish/err got=%b%b%b exp=%b%b%b t=%0t",
                        busy, finish, proto_err, m_busy, m_fin, m_err, $time);
    end
    n_checks++;
    if ({started_cnt, done_cnt, cycle_cnt} !== {m_started, m_done, m_cyc}) begin
      n_err++; $display("FAIL counters got=%0d/%0d/%0d exp=%0d/%0d/%0d t=%0t",
                        started_cnt, done_cnt, cycle_cnt, m_started, m_done, m_cyc, $time);
    end
    n_checks++;
    if ({lat_valid, lat_value} !== {m_lvalid, m_lv}) begin
      n_err++; $display("FAIL latency got=%0b/%0d exp=%0b/%0d t=%0t",
                        lat_valid, lat_value, m_lvalid, m_lv, $time);
    end
    n_checks++;
    if ({lat_max, lat_min} !== {m_max, m_min}) begin
      n_err++; $display("FAIL lat_max/min got=%0d/%0h exp=%0d/%0h t=%0t",
                        lat_max, lat_min, m_max, m_min, $time);
    end
    if (lat_valid === 1'b1) n_pulses++;
    d_out = started_cnt - done_cnt;
    if (int'(d_out) > max_out_seen) max_out_seen = int'(d_out);
    ap_if.ap_done = spur || (k_due.size() > 0 && k_due[0] <= g);
    if (ready_rand) ap_if.ap_ready = 1'($urandom_range(0, 1));
    if (hold_rand)  cont_hold = ($urandom_range(0, 3) == 0);
  endtask

  task automatic start_run(input logic [31:0] num);
    cfg_start = 1; cfg_num = num;
    step();
    cfg_start = 0;
  endtask

  task automatic run_to_finish(input int budget);
    int i = 0;
    while (!m_fin && i < budget) begin step(); i++; end
    n_checks++;
    if (!m_fin || finish !== 1'b1) begin
      n_err++; $display("FAIL run_timeout finish=%0b after %0d cycles exp=1", finish, i);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ap_if.ap_start, ap_if.ap_continue, busy, finish, lat_valid, proto_err} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got=%b exp=000000",
                        {ap_if.ap_start, ap_if.ap_continue, busy, finish, lat_valid, proto_err});
    end
    n_checks++;
    if ({started_cnt, done_cnt, cycle_cnt, lat_value, lat_max} !== 160'b0 || lat_min !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL reset_values got=%0d/%0d/%0d/%0d/%0d min=%0h exp=0s min=ffffffff",
                        started_cnt, done_cnt, cycle_cnt, lat_value, lat_max, lat_min);
    end
  endtask

  task automatic test_basic();
    kdelay = 5; ap_if.ap_ready = 1; cont_hold = 0; n_pulses = 0;
    start_run(3);
    run_to_finish(100);
    n_checks++;
    if (n_pulses != 3) begin n_err++; $display("FAIL basic_pulses got=%0d exp=3", n_pulses); end
    n_checks++;
    if (lat_min !== 32'd5 || lat_max !== 32'd5) begin
      n_err++; $display("FAIL basic_minmax got=%0d/%0d exp=5/5", lat_min, lat_max);
    end
    n_checks++;
    if (started_cnt !== 32'd3 || done_cnt !== 32'd3 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_end got=%0d/%0d busy=%0b exp=3/3 busy=0", started_cnt, done_cnt, busy);
    end
  endtask

  task automatic test_outstanding();
    kdelay = 20; ap_if.ap_ready = 1; max_out_seen = 0; start_low_at_limit = 0;
    start_run(8);
    run_to_finish(300);
    n_checks++;
    if (max_out_seen != 4) begin n_err++; $display("FAIL outst_max got=%0d exp=4", max_out_seen); end
    n_checks++;
    if (!start_low_at_limit) begin n_err++; $display("FAIL outst_stall got=0 exp=1"); end
    n_checks++;
    if (done_cnt !== 32'd8) begin n_err++; $display("FAIL outst_done got=%0d exp=8", done_cnt); end
  endtask

  task automatic test_backpressure();
    int i = 0;
    kdelay = 3; ap_if.ap_ready = 1; cont_hold = 1;
    start_run(1);
    while (ap_if.ap_done !== 1'b1 && i < 20) begin step(); i++; end
    n_checks++;
    if (ap_if.ap_done !== 1'b1) begin n_err++; $display("FAIL bp_wait_done got=0 exp=1"); end
    repeat (10) step();
    n_checks++;
    if (done_cnt !== 32'd0 || ap_if.ap_continue !== 1'b0) begin
      n_err++; $display("FAIL bp_held done=%0d cont=%0b exp=0/0", done_cnt, ap_if.ap_continue);
    end
    cont_hold = 0;
    run_to_finish(20);
    n_checks++;
    if (lat_value !== 32'd13) begin n_err++; $display("FAIL bp_latency got=%0d exp=13", lat_value); end
  endtask

  task automatic test_zero_count();
    saw_start = 0;
    start_run(0);
    n_checks++;
    if (finish !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL zero_finish got=%0b busy=%0b exp=1/0", finish, busy);
    end
    repeat (3) step();
    n_checks++;
    if (saw_start || started_cnt !== 32'd0) begin
      n_err++; $display("FAIL zero_nostart saw=%0b started=%0d exp=0/0", saw_start, started_cnt);
    end
  endtask

  task automatic test_spurious();
    kdelay = 4; ap_if.ap_ready = 0;
    start_run(2);
    spur = 1; ap_if.ap_done = 1;
    step();
    spur = 0; ap_if.ap_done = 0;
    n_checks++;
    if (proto_err !== 1'b1 || done_cnt !== 32'd0) begin
      n_err++; $display("FAIL spur_err got=%0b done=%0d exp=1/0", proto_err, done_cnt);
    end
    ap_if.ap_ready = 1;
    run_to_finish(50);
    n_checks++;
    if (proto_err !== 1'b1 || done_cnt !== 32'd2) begin
      n_err++; $display("FAIL spur_sticky got=%0b done=%0d exp=1/2", proto_err, done_cnt);
    end
    start_run(1);
    n_checks++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL spur_clear got=%0b exp=0", proto_err); end
    run_to_finish(50);
  endtask

  task automatic test_reset_midrun();
    int i = 0;
    kdelay = 15; ap_if.ap_ready = 1;
    start_run(4);
    while (m_done != 2 && i < 60) begin step(); i++; end
    n_checks++;
    if (busy !== 1'b1 || ap_if.ap_continue !== 1'b1 || (started_cnt - done_cnt) !== 32'd2) begin
      n_err++; $display("FAIL midrun_pre busy=%0b cont=%0b outst=%0d exp=1/1/2",
                        busy, ap_if.ap_continue, started_cnt - done_cnt);
    end
    #2 rst_n = 0;
    #1;
    test_reset();
    model_reset();
    ap_if.ap_done = 0;
    #1 rst_n = 1;
    kdelay = 2;
    start_run(1);
    run_to_finish(30);
    n_checks++;
    if (done_cnt !== 32'd1 || lat_value !== 32'd2) begin
      n_err++; $display("FAIL midrun_after got=%0d/%0d exp=1/2", done_cnt, lat_value);
    end
  endtask

  task automatic test_simultaneous();
    kdelay = 3; ap_if.ap_ready = 1;
    start_run(2);
    step();
    ap_if.ap_ready = 0;
    step();
    step();
    ap_if.ap_ready = 1;
    n_checks++;
    if (ap_if.ap_done !== 1'b1 || ap_if.ap_start !== 1'b1) begin
      n_err++; $display("FAIL simul_setup done=%0b start=%0b exp=1/1", ap_if.ap_done, ap_if.ap_start);
    end
    step();
    n_checks++;
    if (started_cnt !== 32'd2 || done_cnt !== 32'd1 || lat_valid !== 1'b1 || lat_value !== 32'd3) begin
      n_err++; $display("FAIL simul got=%0d/%0d v=%0b lat=%0d exp=2/1/1/3",
                        started_cnt, done_cnt, lat_valid, lat_value);
    end
    run_to_finish(30);
  endtask

  task automatic test_random();
    ready_rand = 1; hold_rand = 1; kdelay_rand = 1;
    for (int r = 0; r < 6; r++) begin
      start_run(32'($urandom_range(1, 10)));
      run_to_finish(600);
      n_checks++;
      if (done_cnt !== m_num) begin
        n_err++; $display("FAIL random_run%0d done=%0d exp=%0d", r, done_cnt, m_num);
      end
    end
    ready_rand = 0; hold_rand = 0; kdelay_rand = 0; cont_hold = 0;
  endtask

  initial begin
    rst_n = 0; cfg_start = 0; cfg_num = 0; cont_hold = 0;
    ap_if.ap_ready = 0; ap_if.ap_done = 0;
    kdelay_rand = 0; ready_rand = 0; hold_rand = 0; spur = 0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1;
    test_basic();
    test_outstanding();
    test_backpressure();
    test_zero_count();
    test_spurious();
    test_reset_midrun();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ap_ctrl_chain_driver.md
Name: ap_ctrl_chain_driver

Overview:
- Synthesizable driver for the block-level ap_ctrl_chain handshake of an HLS kernel. It issues a configured number of transactions on ap_start and grants ap_continue under downstream backpressure.
- Per-transaction latency is measured from start acceptance to done, using a timestamp FIFO. This supports up to MAX_OUTSTANDING transactions in flight.
- It is the initiator end of the handshake that the dataflow status monitors only observe. It sits between testbench or host control and the kernel's control ports, and raises finish when the run completes.

Parameters:
- CNT_W, 32, width of transaction count config and counters
- LAT_W, 32, width of cycle counter, timestamps and latency outputs
- MAX_OUTSTANDING, 4, timestamp FIFO depth (power of two, ≥1); started-not-done limit

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- cfg_start  in  1  one-cycle run request
- cfg_num_txn  in  CNT_W  transactions to issue; sampled when cfg_start is accepted
- cont_hold  in  1  downstream backpressure; 1 blocks ap_continue
- ap_start  out  1  kernel start request
- ap_ready  in  1  kernel accepted the current start
- ap_done  in  1  kernel completed a transaction (held until ap_continue)
- ap_continue  out  1  permits the kernel to retire a done
- busy  out  1  state is RUN or DRAIN
- finish  out  1  level; high in FINISH
- started_cnt  out  CNT_W  accepted starts in the current run
- done_cnt  out  CNT_W  retired dones in the current run
- cycle_cnt  out  LAT_W  cycles spent in RUN+DRAIN
- lat_valid  out  1  one-cycle pulse: lat_value is new
- lat_value  out  LAT_W  latency of the last retired transaction
- lat_max  out  LAT_W  maximum latency in the run
- lat_min  out  LAT_W  minimum latency in the run
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, reset=0):
  - State is IDLE.
  - ap_start, ap_continue, busy, finish, lat_valid and proto_err are 0.
  - All counters, lat_value and lat_max are 0; lat_min is all-ones.
  - FIFO is empty.
  - Asserting reset mid-run aborts the run immediately; ap_start drops without waiting for a clock.
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE / FINISH:
  - cfg_start=1 latches cfg_num_txn into num_r.
  - It clears started_cnt, done_cnt, cycle_cnt, lat_*, proto_err and the FIFO, and drops finish.
  - If num_r==0 the next state is FINISH; otherwise RUN.
- cfg_start is ignored while busy.
- RUN:
  - ap_start = (started_cnt < num_r) && (outstanding < MAX_OUTSTANDING), where outstanding = started_cnt − done_cnt.
  - A start is accepted when ap_start && ap_ready. On acceptance the current cycle_cnt is pushed into the FIFO and started_cnt increments.
  - When the last start is accepted, the next state is DRAIN.
  - If the outstanding limit is reached, ap_start deasserts the next cycle and stays low until a retire frees a slot.
- ap_continue = busy && !cont_hold.
- Retire occurs on ap_done && ap_continue:
  - If the FIFO is non-empty at cycle start: pop the head, done_cnt increments.
  - Next cycle: lat_valid=1 and lat_value = (cycle_cnt − head) mod 2^LAT_W; lat_max/lat_min are updated.
  - If the FIFO is empty at cycle start: proto_err is set (sticky), nothing is counted, and the FSM proceeds.
- Accept and retire in the same cycle: push and pop both occur; the outstanding count is unchanged.
- DRAIN:
  - ap_start=0.
  - When done_cnt reaches num_r, the next state is FINISH.
  - Retire and transition may occur in the same cycle: the final lat_valid pulse is emitted in the first FINISH cycle.
- FINISH:
  - finish=1 and busy=0; ap_continue=0.
  - cycle_cnt is frozen.
  - Stays in FINISH until cfg_start.
- cycle_cnt increments every cycle in RUN/DRAIN, starting from 0 on the first RUN cycle, and wraps at 2^LAT_W.
- An ap_ready without ap_start is ignored (no error).
- Latency for a start accepted at cycle T and retired at cycle T+k is k.

Test Plan:
- Basic run: cfg_num_txn=3, kernel with ready same cycle as start and done 5 cycles after accept, cont_hold=0 -> three lat_valid pulses with lat_value=5; lat_min=lat_max=5; started_cnt=done_cnt=3; finish=1 and busy=0 afterwards.
- Outstanding limit: MAX_OUTSTANDING=4, cfg_num_txn=8, ready every cycle, first done only after 20 cycles -> ap_start low after 4 accepts until the first retire; started_cnt never exceeds done_cnt+4; all 8 retire.
- Backpressure: cont_hold=1 for 10 cycles while ap_done=1 -> ap_continue=0, done_cnt unchanged; after release, the retire latency includes the 10 held cycles.
- Zero count plus spurious done: cfg_num_txn=0 -> FINISH next cycle with ap_start never asserted; separately, ap_done in RUN with an empty FIFO -> proto_err=1 stays high until the next cfg_start.
- Reset mid-run: assert reset during DRAIN with 2 outstanding -> all outputs at reset values asynchronously; a new cfg_start with cfg_num_txn=1 completes normally.
- Simultaneous accept and retire: ready and done in the same cycle with 1 outstanding -> outstanding unchanged, both counters increment, latency of the retired entry is correct.
